par_to_seq_stream: RTL

Parametrised parallel-to-serial converter with valid/ready handshakes on both sides. It accepts a PAR_SZ-bit word and emits it as PAR_SZ/SYM_SZ symbols of SYM_SZ bits each, in a bit order selected per word. A one-word holding register lets consecutive words stream with no idle gap. Output backpressure is supported. It sits between word-oriented producers and serial line encoders, replacing the fixed 1-bit, non-handshaked converter.

---
 rtl/par_to_seq_stream_if.sv | 26 ++
 rtl/par_to_seq_stream.sv | 126 ++++++++++++
 2 files changed

// File: rtl/par_to_seq_stream_if.sv
// Word-in / symbol-out handshake bundle for par_to_seq_stream.
// slave is the converter side, master is the producer/consumer side.
interface par_to_seq_stream_if #(
  parameter int PAR_SZ = 8,
  parameter int SYM_SZ = 1
);
  logic [PAR_SZ-1:0] par;
  logic              par_msb_first;
  logic              par_valid;
  logic              par_ready;
  logic [SYM_SZ-1:0] seq;
  logic              seq_valid;
  logic              seq_last;
  logic              seq_ready;
  logic              busy;

  modport master (
    output par, par_msb_first, par_valid, seq_ready,
    input  par_ready, seq, seq_valid, seq_last, busy
  );

  modport slave (
    input  par, par_msb_first, par_valid, seq_ready,
    output par_ready, seq, seq_valid, seq_last, busy
  );
endinterface

// File: rtl/par_to_seq_stream.sv
// Parallel-to-serial converter: PAR_SZ-bit words out as SYM_SZ-bit symbols,
// with a one-word holding register so consecutive words stream gap-free.
module par_to_seq_stream #(
  parameter int              PAR_SZ   = 8,
  parameter int              SYM_SZ   = 1,
  parameter logic [SYM_SZ-1:0] IDLE_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  par_to_seq_stream_if.slave   bus
);
  localparam int NSYM = PAR_SZ / SYM_SZ;
  localparam int CW   = $clog2(NSYM) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSYM - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q;
  logic [PAR_SZ-1:0] shift_q;
  logic [PAR_SZ-1:0] hold_q;
  logic              hold_full_q;
  logic [CW-1:0]     cnt_q;
  logic [SYM_SZ-1:0] seq_q;
  logic              seq_valid_q;
  logic              seq_last_q;

  // Words are normalised to LSB-symbol-first on entry, so the shifter
  // and the holding register never need to remember the bit order.
  logic [PAR_SZ-1:0] par_rev;
  logic [PAR_SZ-1:0] par_norm;

  generate
    for (genvar gi = 0; gi < NSYM; gi++) begin : g_rev
      assign par_rev[gi*SYM_SZ +: SYM_SZ] = bus.par[(NSYM-1-gi)*SYM_SZ +: SYM_SZ];
    end
  endgenerate

  assign par_norm = bus.par_msb_first ? par_rev : bus.par;

  logic par_ready;
  logic accept;
  logic sym_hs;
  logic last_hs;

  assign par_ready = !hold_full_q && !reset;
  assign accept    = bus.par_valid && par_ready;
  assign sym_hs    = seq_valid_q && bus.seq_ready;
  assign last_hs   = sym_hs && seq_last_q;

  logic              load_d;
  logic [PAR_SZ-1:0] load_word_d;
  logic              to_hold_d;
  logic [CW-1:0]     cnt_d;

  always_comb begin
    load_d      = 1'b0;
    load_word_d = par_norm;
    if (state_q == IDLE) begin
      load_d = accept;
    end else if (last_hs) begin
      // A held word takes precedence; otherwise a word arriving right now bypasses.
      if (hold_full_q) begin
        load_d      = 1'b1;
        load_word_d = hold_q;
      end else begin
        load_d = accept;
      end
    end
  end

  assign to_hold_d = accept && (state_q == SHIFT) && !last_hs;
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      seq_q       <= IDLE_VAL;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
    end else begin
      if (to_hold_d) begin
        hold_q      <= par_norm;
        hold_full_q <= 1'b1;
      end else if (last_hs && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (load_d) begin
        state_q     <= SHIFT;
        seq_q       <= load_word_d[SYM_SZ-1:0];
        shift_q     <= load_word_d >> SYM_SZ;
        cnt_q       <= '0;
        seq_valid_q <= 1'b1;
        seq_last_q  <= (LAST_CNT == '0);
      end else begin
        case (state_q)
          SHIFT: begin
            if (last_hs) begin
              state_q     <= IDLE;
              seq_q       <= IDLE_VAL;
              cnt_q       <= '0;
              seq_valid_q <= 1'b0;
              seq_last_q  <= 1'b0;
            end else if (sym_hs) begin
              seq_q      <= shift_q[SYM_SZ-1:0];
              shift_q    <= shift_q >> SYM_SZ;
              cnt_q      <= cnt_d;
              seq_last_q <= (cnt_d == LAST_CNT);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.par_ready = par_ready;
  assign bus.seq       = seq_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.seq_last  = seq_last_q;
  assign bus.busy      = seq_valid_q || hold_full_q;
endmodule
